// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: qualifies address phases, decodes
// the peripheral select, runs the address/data pipeline and the two-cycle ERROR response.
module ahb_slave_interface #(
  parameter logic [5:0] REGION0 = 6'h20,
  parameter logic [5:0] REGION1 = 6'h21,
  parameter logic [5:0] REGION2 = 6'h22
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic        valid,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg,
  output logic [2:0]  temp_selx,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hready_err
);

  // state | meaning
  // IDLE  | OKAY response, no error in progress
  // ERR1  | first ERROR cycle, wait state (hready_err low), inputs ignored
  // ERR2  | second ERROR cycle, new transfer evaluated normally
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t state;
  logic   active;
  logic   illegal;
  logic   unused_htrans0;

  assign unused_htrans0 = htrans[0];

  always_comb begin
    temp_selx = 3'b000;
    if (haddr[31:26] == REGION0)      temp_selx = 3'b001;
    else if (haddr[31:26] == REGION1) temp_selx = 3'b010;
    else if (haddr[31:26] == REGION2) temp_selx = 3'b100;
  end

  assign active  = hreadyin & hresetn & htrans[1];
  assign illegal = (temp_selx == 3'b000)
                 | (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (|haddr[1:0]));
  assign valid   = active & ~illegal & (state != ST_ERR1);
  assign hrdata  = prdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1     <= '0;
      haddr2     <= '0;
      hwdata1    <= '0;
      hwdata2    <= '0;
      hwrite_reg <= 1'b0;
    end else if (hreadyin) begin
      haddr1     <= haddr;
      haddr2     <= haddr1;
      hwdata1    <= hwdata;
      hwdata2    <= hwdata1;
      hwrite_reg <= hwrite;
    end
  end

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= ST_IDLE;
      hresp      <= 2'b00;
      hready_err <= 1'b1;
    end else begin
      case (state)
        ST_ERR1: begin
          state      <= ST_ERR2;
          hresp      <= 2'b01;
          hready_err <= 1'b1;
        end
        default: begin
          if (active && illegal) begin
            state      <= ST_ERR1;
            hresp      <= 2'b01;
            hready_err <= 1'b0;
          end else begin
            state      <= ST_IDLE;
            hresp      <= 2'b00;
            hready_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
